fwd_stall_unit: RTL and testbench
=================================

FWD_STALL_UNIT -- requirements
Module: fwd_stall_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of every data port.
REQ-002 Parameter AW, default 5: register-address width; register 0 is hard-wired zero.
REQ-003 Parameter MULT_LAT, default 5: HI/LO busy cycles after a mult start.
REQ-004 Parameter DIV_LAT, default 10: HI/LO busy cycles after a div start.
REQ-005 Parameter W2D_FWD, default 1: 1 = W result also forwarded into D; 0 = rely on GRF write-through.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 D_rs, D_rt  input  AW  source addresses of the instruction in D.
REQ-009 D_tuse_rs, D_tuse_rt  input  2  cycles until operand needed (0 = D, 1 = E, 2 = M, 3 = unused).
REQ-010 D_wa  input  AW  destination of the D instruction (0 = none).
REQ-011 D_tnew  input  2  cycles after entering E until the result exists (0 lui/jal, 1 ALU, 2 load).
REQ-012 D_md_use, D_md_start, D_md_div  input  1 each  HI/LO user; mult/div start; start is div.
REQ-013 D_grf_rs, D_grf_rt, E_rs_val, E_rt_val, M_rt_val  input  DATA_W  unforwarded operands.
REQ-014 E_wd, M_wd, W_wd  input  DATA_W  result currently produced in E, M, W.
REQ-015 stall  output  1  freeze F/D, insert bubble into E.
REQ-016 D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd  output  DATA_W  forwarded operands.
REQ-017 md_busy  output  1  HI/LO unit occupied.

Function
REQ-018 Unit SHALL hold a scoreboard {rs, rt, wa, tnew} for E, M, W, advancing D->E->M->W each clk.
REQ-019 On advance tnew SHALL decrement, saturating at 0.
REQ-020 When stall=1, E entry SHALL load a bubble (all fields 0); M and W advance normally.
REQ-021 stall_rs SHALL = D_rs!=0 and tuse_rs!=3 and (D_rs==E.wa and E.tnew>tuse_rs, or D_rs==M.wa and M.tnew>tuse_rs); stall_rt likewise.
REQ-022 stall_md SHALL = (D_md_use or D_md_start) and (md_busy or E carries a start).
REQ-023 stall SHALL = stall_rs | stall_rt | stall_md, combinational, same cycle.
REQ-024 Forward priority SHALL be E > M > W; a stage matches only if addr!=0, addr==stage.wa, stage.tnew==0.
REQ-025 D operands select E_wd/M_wd/(W_wd if W2D_FWD) else D_grf_*; E operands M_wd/W_wd else E_*_val; M_rt_fwd W_wd else M_rt_val.
REQ-026 Match with tnew>0 in a younger stage SHALL block older-stage forwarding for that operand.
REQ-027 md counter SHALL load MULT_LAT or DIV_LAT when a start leaves E; md_busy = counter!=0; decrement to 0.
REQ-028 A new start while busy SHALL be impossible (stalled in D by REQ-022).
REQ-029 Forward outputs SHALL be combinational (zero latency); scoreboard update one cycle.

Reset
REQ-030 reset_n low SHALL clear all scoreboard entries and md counter immediately, regardless of clk.
REQ-031 During and after reset stall=0, md_busy=0, forwards equal unforwarded inputs.
REQ-032 Reset mid-stall or mid-divide SHALL abandon it; no stall in the first cycle after release.

Structure
REQ-033 Shared package holds TUSE_NONE=3, TNEW encodings, scoreboard-entry struct, default latencies.
REQ-034 One sub-module md_busy_cnt (latency counter) is natural; rest lives in fwd_stall_unit.

Verification
REQ-035 lw $1 then addu using $1 (tuse 1): stall=1 exactly 1 cycle, then E_rs_fwd=W_wd... per M result 0x1234.
REQ-036 addu $2 then beq $2 (tuse 0): stall 1 cycle, next cycle D_rs_fwd=M_wd=0x55.
REQ-037 Writes to $0 with E_wd=0xFFFF: no stall, D_rs_fwd=D_grf_rs=0.
REQ-038 $3 written in E (tnew 0, 0xA) and M (0xB): D_rs_fwd=0xA (priority).
REQ-039 div then mflo: md_busy 10 cycles after div leaves E, mflo stalled until counter 0.
REQ-040 reset_n low during div busy: md_busy=0 and stall=0 asynchronously, scoreboard empty.

Source files
------------

// File: rtl/fwd_stall_unit_pkg.sv
// rtl/fwd_stall_unit_pkg.sv - shared encodings, latencies and scoreboard entry for fwd_stall_unit
// Contents: TUSE/TNEW encodings, default HI/LO latencies, scoreboard entry struct, tnew ageing helper.
package fwd_stall_unit_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;   // operand never read from the register file

    localparam logic [1:0] TNEW_NOW  = 2'd0;   // lui/jal: result ready on entering E
    localparam logic [1:0] TNEW_ALU  = 2'd1;   // ALU: result ready on entering M
    localparam logic [1:0] TNEW_LOAD = 2'd2;   // load: result ready on entering W

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    // Address fields are held at a fixed maximum width so the struct can live here;
    // the top zero-extends its AW-bit addresses into them.
    localparam int SB_AW_MAX = 8;

    typedef struct packed {
        logic [SB_AW_MAX-1:0] rs;
        logic [SB_AW_MAX-1:0] rt;
        logic [SB_AW_MAX-1:0] wa;
        logic [1:0]           tnew;
        logic                 md_start;
        logic                 md_div;
    } sb_entry_t;

    // One pipeline step closer to the result, never below "ready now".
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/fwd_stall_unit_md_busy_cnt.sv
// rtl/fwd_stall_unit_md_busy_cnt.sv - HI/LO unit occupancy counter
// Ports: clk, reset_n (async active-low), start_i (mult/div leaving E this cycle),
//        is_div_i (that start is a divide), busy_o (counter non-zero).
module md_busy_cnt #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = is_div_i ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fwd_stall_unit.sv
// rtl/fwd_stall_unit.sv - pipeline hazard unit: E/M/W scoreboard, stall detection, operand forwarding
// Inputs:  clk, reset_n (async active-low); D_* decode-stage instruction info and GRF operands;
//          E_rs_val/E_rt_val/M_rt_val unforwarded later-stage operands; E_wd/M_wd/W_wd stage results.
// Outputs: stall (freeze F/D, bubble into E), D/E/M forwarded operands, md_busy (HI/LO occupied).
module fwd_stall_unit
    import fwd_stall_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int AW       = 5,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int W2D_FWD  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     D_rs,
    input  logic [AW-1:0]     D_rt,
    input  logic [1:0]        D_tuse_rs,
    input  logic [1:0]        D_tuse_rt,
    input  logic [AW-1:0]     D_wa,
    input  logic [1:0]        D_tnew,
    input  logic              D_md_use,
    input  logic              D_md_start,
    input  logic              D_md_div,
    input  logic [DATA_W-1:0] D_grf_rs,
    input  logic [DATA_W-1:0] D_grf_rt,
    input  logic [DATA_W-1:0] E_rs_val,
    input  logic [DATA_W-1:0] E_rt_val,
    input  logic [DATA_W-1:0] M_rt_val,
    input  logic [DATA_W-1:0] E_wd,
    input  logic [DATA_W-1:0] M_wd,
    input  logic [DATA_W-1:0] W_wd,
    output logic              stall,
    output logic [DATA_W-1:0] D_rs_fwd,
    output logic [DATA_W-1:0] D_rt_fwd,
    output logic [DATA_W-1:0] E_rs_fwd,
    output logic [DATA_W-1:0] E_rt_fwd,
    output logic [DATA_W-1:0] M_rt_fwd,
    output logic              md_busy
);

    if (AW > SB_AW_MAX) begin : g_aw_too_wide
        $error("fwd_stall_unit: AW exceeds scoreboard address width");
    end

    localparam logic W2D_EN = (W2D_FWD != 0);

    sb_entry_t e_q, m_q, w_q;
    sb_entry_t e_d, m_d, w_d;

    logic [SB_AW_MAX-1:0] d_rs_x, d_rt_x, d_wa_x;
    logic stall_rs, stall_rt, stall_md;

    assign d_rs_x = SB_AW_MAX'(D_rs);
    assign d_rt_x = SB_AW_MAX'(D_rt);
    assign d_wa_x = SB_AW_MAX'(D_wa);

    // A producer in stage s blocks the reader when its result will not exist by the time
    // the reader needs it (tnew > tuse).
    function automatic logic raw_hazard(input logic [SB_AW_MAX-1:0] addr,
                                        input logic [1:0]           tuse,
                                        input sb_entry_t            s);
        return (addr != '0) && (tuse != TUSE_NONE) && (s.wa == addr) && (s.tnew > tuse);
    endfunction

    // One forwarding level: if this stage owns the address it decides the value (its result
    // when ready, otherwise the stale default, since an older copy would be wrong);
    // otherwise defer to the older stages' choice in `rest`.
    function automatic logic [DATA_W-1:0] fwd1(input logic [SB_AW_MAX-1:0] addr,
                                               input logic [DATA_W-1:0]    dflt,
                                               input sb_entry_t            s,
                                               input logic [DATA_W-1:0]    wd,
                                               input logic                 en,
                                               input logic [DATA_W-1:0]    rest);
        if ((addr != '0) && (s.wa == addr)) begin
            return (en && (s.tnew == 2'd0)) ? wd : dflt;
        end
        return rest;
    endfunction

    assign stall_rs = raw_hazard(d_rs_x, D_tuse_rs, e_q) || raw_hazard(d_rs_x, D_tuse_rs, m_q);
    assign stall_rt = raw_hazard(d_rt_x, D_tuse_rt, e_q) || raw_hazard(d_rt_x, D_tuse_rt, m_q);
    // A start still in E has not loaded the counter yet, so it must be checked separately.
    assign stall_md = (D_md_use || D_md_start) && (md_busy || e_q.md_start);
    assign stall    = stall_rs || stall_rt || stall_md;

    assign D_rs_fwd = fwd1(d_rs_x, D_grf_rs, e_q, E_wd, 1'b1,
                      fwd1(d_rs_x, D_grf_rs, m_q, M_wd, 1'b1,
                      fwd1(d_rs_x, D_grf_rs, w_q, W_wd, W2D_EN, D_grf_rs)));
    assign D_rt_fwd = fwd1(d_rt_x, D_grf_rt, e_q, E_wd, 1'b1,
                      fwd1(d_rt_x, D_grf_rt, m_q, M_wd, 1'b1,
                      fwd1(d_rt_x, D_grf_rt, w_q, W_wd, W2D_EN, D_grf_rt)));
    assign E_rs_fwd = fwd1(e_q.rs, E_rs_val, m_q, M_wd, 1'b1,
                      fwd1(e_q.rs, E_rs_val, w_q, W_wd, 1'b1, E_rs_val));
    assign E_rt_fwd = fwd1(e_q.rt, E_rt_val, m_q, M_wd, 1'b1,
                      fwd1(e_q.rt, E_rt_val, w_q, W_wd, 1'b1, E_rt_val));
    assign M_rt_fwd = fwd1(m_q.rt, M_rt_val, w_q, W_wd, 1'b1, M_rt_val);

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d = '{rs: d_rs_x, rt: d_rt_x, wa: d_wa_x, tnew: D_tnew,
                    md_start: D_md_start, md_div: D_md_div};
        end
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (e_q.md_start),
        .is_div_i (e_q.md_div),
        .busy_o   (md_busy)
    );

    // Fields carried along the pipe that no later-stage logic reads.
    logic sb_unused;
    assign sb_unused = ^{m_q.rs, m_q.md_start, m_q.md_div,
                         w_q.rs, w_q.rt, w_q.md_start, w_q.md_div};

endmodule

// File: tb/tb_fwd_stall_unit.sv
// tb/tb_fwd_stall_unit.sv - self-checking bench for fwd_stall_unit
module tb_fwd_stall_unit;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int ML  = 5;
    localparam int DL  = 10;
    localparam int W2D = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] D_rs, D_rt, D_wa;
    logic [1:0]    D_tuse_rs, D_tuse_rt, D_tnew;
    logic          D_md_use, D_md_start, D_md_div;
    logic [DW-1:0] D_grf_rs, D_grf_rt, E_rs_val, E_rt_val, M_rt_val, E_wd, M_wd, W_wd;
    logic          stall, md_busy;
    logic [DW-1:0] D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd;

    always #5 clk = ~clk;

    fwd_stall_unit #(.DATA_W(DW), .AW(AW), .MULT_LAT(ML), .DIV_LAT(DL), .W2D_FWD(W2D)) dut (
        .clk(clk), .reset_n(reset_n),
        .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
        .D_wa(D_wa), .D_tnew(D_tnew), .D_md_use(D_md_use), .D_md_start(D_md_start),
        .D_md_div(D_md_div), .D_grf_rs(D_grf_rs), .D_grf_rt(D_grf_rt),
        .E_rs_val(E_rs_val), .E_rt_val(E_rt_val), .M_rt_val(M_rt_val),
        .E_wd(E_wd), .M_wd(M_wd), .W_wd(W_wd), .stall(stall),
        .D_rs_fwd(D_rs_fwd), .D_rt_fwd(D_rt_fwd), .E_rs_fwd(E_rs_fwd),
        .E_rt_fwd(E_rt_fwd), .M_rt_fwd(M_rt_fwd), .md_busy(md_busy)
    );

    // Instruction presented in D.
    typedef struct {
        int rs; int rt; int wa; int tuse_rs; int tuse_rt; int tnew;
        bit md_use; bit md_start; bit md_div;
    } dins_t;

    // Instruction in flight: result exists from absolute cycle `ready` onward.
    typedef struct {
        int rs; int rt; int wa; int ready; bit md_start; bit md_div;
    } pins_t;

    typedef struct {
        bit stall; bit busy;
        logic [DW-1:0] drs; logic [DW-1:0] drt; logic [DW-1:0] ers;
        logic [DW-1:0] ert; logic [DW-1:0] mrt;
    } exp_t;

    exp_t  exp_q[$];
    pins_t pipe[3];      // 0 = E, 1 = M, 2 = W
    int    now;
    int    md_end;       // last cycle on which HI/LO is occupied
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0, 0};
        now    = 0;
        md_end = -1000;
    endfunction

    function automatic int rem(int k);
        int r;
        r = pipe[k].ready - now;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit need_wait(int a, int tuse);
        if (a == 0 || tuse == 3) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wa == a && rem(k) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] stage_wd(int k);
        return (k == 0) ? E_wd : (k == 1) ? M_wd : W_wd;
    endfunction

    // Youngest stage owning the address decides; its result only if already produced.
    function automatic logic [DW-1:0] fwd(int a, int first, bit allow_w, logic [DW-1:0] dflt);
        for (int k = first; k < 3; k++) begin
            if (a != 0 && pipe[k].wa == a) begin
                if (rem(k) == 0 && (k != 2 || allow_w)) return stage_wd(k);
                return dflt;
            end
        end
        return dflt;
    endfunction

    function automatic bit model_stall(dins_t d);
        bit busy_or_pending;
        busy_or_pending = (now <= md_end) || pipe[0].md_start;
        return need_wait(d.rs, d.tuse_rs) || need_wait(d.rt, d.tuse_rt) ||
               ((d.md_use || d.md_start) && busy_or_pending);
    endfunction

    function automatic void model_advance(dins_t d, bit st);
        if (pipe[0].md_start) md_end = now + (pipe[0].md_div ? DL : ML);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (st) pipe[0] = '{0, 0, 0, 0, 0, 0};
        else    pipe[0] = '{d.rs, d.rt, d.wa, now + 1 + d.tnew, d.md_start, d.md_div};
        now++;
    endfunction

    task automatic drive(input dins_t d);
        D_rs = AW'(d.rs); D_rt = AW'(d.rt); D_wa = AW'(d.wa);
        D_tuse_rs = 2'(d.tuse_rs); D_tuse_rt = 2'(d.tuse_rt); D_tnew = 2'(d.tnew);
        D_md_use = d.md_use; D_md_start = d.md_start; D_md_div = d.md_div;
        D_grf_rs = $urandom; D_grf_rt = $urandom; E_rs_val = $urandom;
        E_rt_val = $urandom; M_rt_val = $urandom;
        E_wd = $urandom; M_wd = $urandom; W_wd = $urandom;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic step(input dins_t d, output bit st_model, output bit st_dut);
        exp_t e;
        drive(d);
        st_model = model_stall(d);
        e.stall = st_model;
        e.busy  = (now <= md_end);
        e.drs   = fwd(d.rs, 0, W2D != 0, D_grf_rs);
        e.drt   = fwd(d.rt, 0, W2D != 0, D_grf_rt);
        e.ers   = fwd(pipe[0].rs, 1, 1'b1, E_rs_val);
        e.ert   = fwd(pipe[0].rt, 1, 1'b1, E_rt_val);
        e.mrt   = fwd(pipe[1].rt, 2, 1'b1, M_rt_val);
        exp_q.push_back(e);
        #2;
        st_dut = stall;
        @(posedge clk);
        model_advance(d, st_model);
        #1;
    endtask

    // Hold the instruction in D until it is accepted; returns stall cycles the DUT showed.
    task automatic run(input dins_t d, output int dut_stalls);
        bit sm, sd;
        bit done;
        dut_stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(d, sm, sd);
            if (sd) dut_stalls++;
            if (!sm) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: instruction never left D at t=%0t", $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall",    {31'd0, stall},   {31'd0, e.stall});
            chk("md_busy",  {31'd0, md_busy}, {31'd0, e.busy});
            chk("D_rs_fwd", D_rs_fwd, e.drs);
            chk("D_rt_fwd", D_rt_fwd, e.drt);
            chk("E_rs_fwd", E_rs_fwd, e.ers);
            chk("E_rt_fwd", E_rt_fwd, e.ert);
            chk("M_rt_fwd", M_rt_fwd, e.mrt);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        dins_t nop, d;
        int    ns;
        nop = '{0, 0, 0, 3, 3, 0, 0, 0, 0};
        model_reset();
        reset_n = 1'b0;
        drive('{1, 2, 1, 0, 0, 1, 1, 1, 1});
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall",   {31'd0, stall},   32'd0);
        chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_D_rs",    D_rs_fwd, D_grf_rs);
        chk("rst_E_rt",    E_rt_fwd, E_rt_val);
        chk("rst_M_rt",    M_rt_fwd, M_rt_val);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // lw $1 ; addu $4,$1 (E use) -> one stall
        run('{0, 0, 1, 3, 3, 2, 0, 0, 0}, ns);
        run('{1, 0, 4, 1, 3, 1, 0, 0, 0}, ns);
        chk("lw_use_stalls", ns, 1);
        repeat (3) run(nop, ns);

        // addu $2 ; beq $2 (D use) -> one stall, then M forward
        run('{0, 0, 2, 3, 3, 1, 0, 0, 0}, ns);
        run('{2, 0, 0, 0, 3, 0, 0, 0, 0}, ns);
        chk("alu_branch_stalls", ns, 1);
        repeat (3) run(nop, ns);

        // writes to $0 never hazard
        run('{0, 0, 0, 3, 3, 2, 0, 0, 0}, ns);
        run('{0, 0, 0, 0, 0, 0, 0, 0, 0}, ns);
        chk("zero_reg_stalls", ns, 0);
        repeat (3) run(nop, ns);

        // $3 in M and E, both ready: E wins
        run('{0, 0, 3, 3, 3, 0, 0, 0, 0}, ns);
        run('{0, 0, 3, 3, 3, 0, 0, 0, 0}, ns);
        run('{3, 3, 0, 0, 0, 0, 0, 0, 0}, ns);
        chk("priority_stalls", ns, 0);
        repeat (3) run(nop, ns);

        // div ; mflo -> held 1 cycle (start in E) + DIV_LAT busy cycles
        run('{0, 0, 0, 3, 3, 0, 0, 1, 1}, ns);
        run('{0, 0, 5, 3, 3, 1, 1, 0, 0}, ns);
        chk("div_mflo_stalls", ns, 1 + DL);
        repeat (3) run(nop, ns);

        // mult ; mfhi -> 1 + MULT_LAT
        run('{0, 0, 0, 3, 3, 0, 0, 1, 0}, ns);
        run('{0, 0, 6, 3, 3, 1, 1, 0, 0}, ns);
        chk("mult_mfhi_stalls", ns, 1 + ML);
        repeat (3) run(nop, ns);

        // reset while divide is busy and mflo is waiting
        run('{0, 0, 0, 3, 3, 0, 0, 1, 1}, ns);
        repeat (3) run(nop, ns);
        d = '{0, 0, 7, 3, 3, 1, 1, 0, 0};
        drive(d);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_div_busy",  {31'd0, md_busy}, 32'd0);
        chk("rst_mid_div_stall", {31'd0, stall},   32'd0);
        chk("rst_mid_div_D_rs",  D_rs_fwd, D_grf_rs);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        run(d, ns);
        chk("post_reset_stalls", ns, 0);

        // randomized instruction stream over a small register window
        for (int i = 0; i < 400; i++) begin
            d.rs       = $urandom_range(0, 3);
            d.rt       = $urandom_range(0, 3);
            d.wa       = $urandom_range(0, 3);
            d.tuse_rs  = $urandom_range(0, 3);
            d.tuse_rt  = $urandom_range(0, 3);
            d.tnew     = $urandom_range(0, 2);
            d.md_use   = ($urandom_range(0, 9) == 0);
            d.md_start = ($urandom_range(0, 11) == 0);
            d.md_div   = $urandom_range(0, 1);
            run(d, ns);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
